// File: rtl/ctrl_unit_pkg.sv
// Shared definitions for the multicycle CPU main controller: state encodings,
// opcode/funct constants, ALU op codes, mux select codes and the instruction
// classifier used at decode time.
package ctrl_unit_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_IR_LOAD = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC_R  = 4'd4,
    S_EXEC_I  = 4'd5,
    S_ADDR    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_R    = 4'd9,
    S_WB_I    = 4'd10,
    S_WB_MEM  = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13,
    S_EXC     = 4'd14
  } state_t;

  // Instruction classes resolved from opcode/funct
  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_ADDI = 4'd3,
    CLS_LW   = 4'd4,
    CLS_SW   = 4'd5,
    CLS_BEQ  = 4'd6,
    CLS_BNE  = 4'd7,
    CLS_J    = 4'd8,
    CLS_BAD  = 4'd9
  } instr_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_LOADA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  // Map the raw instruction fields onto a class; unknown encodings are CLS_BAD
  function automatic instr_cls_t decode_cls(input logic [5:0] opcode,
                                            input logic [5:0] funct);
    instr_cls_t cls;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls = CLS_ADD;
          FN_SUB:  cls = CLS_SUB;
          FN_AND:  cls = CLS_AND;
          default: cls = CLS_BAD;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Multicycle main controller (Moore FSM). Sequences fetch / decode / execute /
// memory / writeback, holds memory states for MEM_WAIT cycles and diverts to
// the exception state on an invalid instruction or arithmetic overflow.
// The instruction class is captured in DECODE so that execute-stage outputs
// (ALU op, branch sense) come from flops rather than from opcode/funct.
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int          MEM_WAIT   = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        overflow,
  input  logic        zero,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg_dest,
  output logic        ab_load,
  output logic        aluout_load,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  pc_source,
  output logic        epc_write,
  output logic [31:0] exc_addr,
  output logic [3:0]  state_dbg
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             wait_done_s;
  instr_cls_t       cls_r;
  instr_cls_t       cls_dec_s;

  assign wait_done_s = (wait_cnt_r == CNT_LAST);
  assign cls_dec_s   = decode_cls(opcode, funct);
  assign exc_addr    = EXC_VECTOR;
  assign state_dbg   = state_r;

  // State register; reset forces RESET immediately so all outputs drop at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_RESET;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory wait counter: restarts on every state change, saturates at MEM_WAIT-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (!wait_done_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Capture the instruction class while the IR is decoded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_r <= CLS_BAD;
    end else if (state_r == S_DECODE) begin
      cls_r <= cls_dec_s;
    end else begin
      cls_r <= cls_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_RESET:   next_state_s = S_FETCH;
      S_FETCH: begin
        if (wait_done_s) next_state_s = S_IR_LOAD;
        else             next_state_s = S_FETCH;
      end
      S_IR_LOAD: next_state_s = S_DECODE;
      S_DECODE: begin
        case (cls_dec_s)
          CLS_ADD, CLS_SUB, CLS_AND: next_state_s = S_EXEC_R;
          CLS_ADDI:                  next_state_s = S_EXEC_I;
          CLS_LW, CLS_SW:            next_state_s = S_ADDR;
          CLS_BEQ, CLS_BNE:          next_state_s = S_BRANCH;
          CLS_J:                     next_state_s = S_JUMP;
          default:                   next_state_s = S_EXC;
        endcase
      end
      S_EXEC_R: begin
        // AND cannot overflow; only add/sub are diverted
        if (overflow && (cls_r != CLS_AND)) next_state_s = S_EXC;
        else                                next_state_s = S_WB_R;
      end
      S_EXEC_I: begin
        if (overflow) next_state_s = S_EXC;
        else          next_state_s = S_WB_I;
      end
      S_ADDR: begin
        if (cls_r == CLS_SW) next_state_s = S_MEM_WR;
        else                 next_state_s = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (wait_done_s) next_state_s = S_WB_MEM;
        else             next_state_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (wait_done_s) next_state_s = S_FETCH;
        else             next_state_s = S_MEM_WR;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_EXC: next_state_s = S_FETCH;
      default:   next_state_s = S_RESET;
    endcase
  end

  // Output decode from the current state (branch enable also qualifies on ALU zero)
  always_comb begin
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dest    = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    alu_control = ALU_LOADA;
    pc_source   = PCSRC_ALU;
    epc_write   = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
      end
      S_IR_LOAD: begin
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        pc_source   = PCSRC_ALU;
      end
      S_DECODE: begin
        ab_load     = 1'b1;
        aluout_load = 1'b1;
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        aluout_load = 1'b1;
        case (cls_r)
          CLS_SUB: alu_control = ALU_SUB;
          CLS_AND: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        aluout_load = 1'b1;
      end
      S_MEM_RD: iord = 1'b1;
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_WB_R: begin
        reg_dest  = 1'b1;
        reg_write = 1'b1;
      end
      S_WB_I:   reg_write = 1'b1;
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        pc_write    = ((cls_r == CLS_BEQ) && zero) || ((cls_r == CLS_BNE) && !zero);
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_source = PCSRC_EXC;
        pc_write  = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: a reference model expands each instruction
// into its expected per-cycle output sequence, a monitor pops and compares.
module tb_ctrl_unit;
  import ctrl_unit_pkg::*;

  localparam int          MW    = 2;
  localparam logic [31:0] EXC_V = 32'hFC;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ADDI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_BNE = 7, K_J = 8, K_BAD = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        overflow, zero;
  logic        pc_write, iord, mem_write, ir_write, reg_write, mem_to_reg, reg_dest;
  logic        ab_load, aluout_load, alu_src_a, epc_write;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_control;
  logic [31:0] exc_addr;
  logic [3:0]  state_dbg;

  ctrl_unit #(.MEM_WAIT(MW), .EXC_VECTOR(EXC_V)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .overflow(overflow), .zero(zero), .pc_write(pc_write), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .ab_load(ab_load),
    .aluout_load(aluout_load), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_source(pc_source), .epc_write(epc_write),
    .exc_addr(exc_addr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_write, iord, mem_write, ir_write, reg_write, mem_to_reg, reg_dest;
    logic        ab_load, aluout_load, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  pc_source;
    logic        epc_write;
    logic [31:0] exc_addr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t idle(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.exc_addr = EXC_V;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_dbg;           o.pc_write = pc_write;     o.iord = iord;
    o.mem_write = mem_write;    o.ir_write = ir_write;     o.reg_write = reg_write;
    o.mem_to_reg = mem_to_reg;  o.reg_dest = reg_dest;     o.ab_load = ab_load;
    o.aluout_load = aluout_load; o.alu_src_a = alu_src_a;  o.alu_src_b = alu_src_b;
    o.alu_control = alu_control; o.pc_source = pc_source;  o.epc_write = epc_write;
    o.exc_addr = exc_addr;
    return o;
  endfunction

  // Monitor: every cycle with pending expectations, pop one and compare
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t w, g;
      w = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== w) begin
        errors++;
        $display("FAIL outputs t=%0t: got st=%0d %h, want st=%0d %h", $time, g.st, g, w.st, w);
      end
    end
  end

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h24) return K_AND;
      return K_BAD;
    end
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h05) return K_BNE;
    if (op == 6'h02) return K_J;
    return K_BAD;
  endfunction

  task automatic push_exc();
    obs_t o;
    o = idle(S_EXC); o.epc_write = 1'b1; o.pc_source = 2'd3; o.pc_write = 1'b1;
    exp_q.push_back(o);
  endtask

  // Reference model: expected cycle-by-cycle outputs for one instruction
  task automatic expect_instr(input logic [5:0] op, input logic [5:0] fn,
                              input logic ovf, input logic z);
    obs_t o;
    int k;
    k = kind(op, fn);
    repeat (MW) begin
      o = idle(S_FETCH); o.alu_src_b = 2'd1; o.alu_control = 3'b001;
      exp_q.push_back(o);
    end
    o = idle(S_IR_LOAD); o.ir_write = 1'b1; o.pc_write = 1'b1;
    o.alu_src_b = 2'd1; o.alu_control = 3'b001;
    exp_q.push_back(o);
    o = idle(S_DECODE); o.ab_load = 1'b1; o.aluout_load = 1'b1;
    o.alu_src_b = 2'd3; o.alu_control = 3'b001;
    exp_q.push_back(o);
    if (k == K_ADD || k == K_SUB || k == K_AND) begin
      o = idle(S_EXEC_R); o.alu_src_a = 1'b1; o.aluout_load = 1'b1;
      o.alu_control = (k == K_SUB) ? 3'b010 : ((k == K_AND) ? 3'b011 : 3'b001);
      exp_q.push_back(o);
      if (ovf && k != K_AND) push_exc();
      else begin
        o = idle(S_WB_R); o.reg_dest = 1'b1; o.reg_write = 1'b1;
        exp_q.push_back(o);
      end
    end else if (k == K_ADDI || k == K_LW || k == K_SW) begin
      o = idle((k == K_ADDI) ? S_EXEC_I : S_ADDR);
      o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_control = 3'b001; o.aluout_load = 1'b1;
      exp_q.push_back(o);
      if (k == K_ADDI) begin
        if (ovf) push_exc();
        else begin
          o = idle(S_WB_I); o.reg_write = 1'b1;
          exp_q.push_back(o);
        end
      end else if (k == K_LW) begin
        repeat (MW) begin
          o = idle(S_MEM_RD); o.iord = 1'b1;
          exp_q.push_back(o);
        end
        o = idle(S_WB_MEM); o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
        exp_q.push_back(o);
      end else begin
        repeat (MW) begin
          o = idle(S_MEM_WR); o.iord = 1'b1; o.mem_write = 1'b1;
          exp_q.push_back(o);
        end
      end
    end else if (k == K_BEQ || k == K_BNE) begin
      o = idle(S_BRANCH); o.alu_src_a = 1'b1; o.alu_control = 3'b010; o.pc_source = 2'd1;
      o.pc_write = (k == K_BEQ) ? z : ~z;
      exp_q.push_back(o);
    end else if (k == K_J) begin
      o = idle(S_JUMP); o.pc_source = 2'd2; o.pc_write = 1'b1;
      exp_q.push_back(o);
    end else begin
      push_exc();
    end
  endtask

  // Wait until the monitor has consumed every expectation, bounded
  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic ovf, input logic z, input bit fresh);
    if (!fresh) begin
      @(posedge clk);
      #1;
    end
    opcode = op; funct = fn; overflow = ovf; zero = z;
    expect_instr(op, fn, ovf, z);
    drain();
  endtask

  initial begin
    obs_t g, w;
    logic [5:0] op, fn;
    logic ovf, z;
    int sel;
    opcode = 6'h00; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) exp_q.push_back(idle(S_RESET));
    drain();
    reset = 1'b1;
    run(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);   // add
    run(6'h00, 6'h22, 1'b0, 1'b1, 1'b0);   // sub
    run(6'h00, 6'h24, 1'b1, 1'b0, 1'b0);   // and, overflow ignored
    run(6'h23, 6'h11, 1'b0, 1'b0, 1'b0);   // lw
    run(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);   // sw
    run(6'h04, 6'h00, 1'b0, 1'b1, 1'b0);   // beq taken
    run(6'h04, 6'h00, 1'b0, 1'b0, 1'b0);   // beq not taken
    run(6'h05, 6'h00, 1'b0, 1'b1, 1'b0);   // bne not taken
    run(6'h05, 6'h00, 1'b0, 1'b0, 1'b0);   // bne taken
    run(6'h02, 6'h00, 1'b0, 1'b0, 1'b0);   // j
    run(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);   // invalid opcode
    run(6'h08, 6'h00, 1'b1, 1'b0, 1'b0);   // addi overflow
    run(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);   // add overflow
    run(6'h00, 6'h21, 1'b0, 1'b0, 1'b0);   // bad funct

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      fn  = 6'($urandom_range(0, 63));
      case (sel)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h22; end
        2: begin op = 6'h00; fn = 6'h24; end
        3: op = 6'h08;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h05;
        8: op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ovf = ($urandom_range(0, 3) == 0);
      z   = 1'($urandom_range(0, 1));
      run(op, fn, ovf, z, 1'b0);
    end

    // Reset asserted in the first MEM_WR cycle of a store
    @(posedge clk);
    #1;
    opcode = 6'h2B; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
    expect_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 100 && exp_q.size() > MW - 1; i++) begin
      @(negedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    g = sample();
    w = idle(S_RESET);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL async_reset: got st=%0d mem_write=%0b, want st=%0d mem_write=0", g.st, g.mem_write, w.st);
    end
    exp_q.delete();
    exp_q.push_back(idle(S_RESET));
    drain();
    reset = 1'b1;
    run(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);   // restart from FETCH

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
